// File: rtl/vector5_pkg.sv
// Shared definitions for the 5-input pairwise-equality encoder/decoder pair.
package vector5_pkg;

  localparam int unsigned N = 5;
  localparam int unsigned W = 25;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  // Bit position of E(r,c) inside the 25-bit word; index 0 is input a.
  function automatic int unsigned pair_idx(input int unsigned r, input int unsigned c);
    return W - 1 - N * r - c;
  endfunction

endpackage

// File: rtl/vector5_row_check.sv
// Checks one row of the pairwise-equality word against the reference vector.
module vector5_row_check
  import vector5_pkg::*;
(
  input  logic [N-1:0] row,
  input  logic [N-1:0] ref_vec,
  input  logic [2:0]   row_idx,
  output logic         mismatch
);

  logic         ref_r;
  logic [N-1:0] expected;

  // Element c must equal ~(ref_r ^ ref_c): a copy of ref_vec when ref_r is 1, its inverse otherwise.
  always_comb begin
    ref_r    = ref_vec[3'd4 - row_idx];
    expected = ref_r ? ref_vec : ~ref_vec;
    mismatch = (row != expected);
  end

endmodule

// File: rtl/vector5_pair_decoder.sv
// Recovers the a=0-normalised 5-bit source from a pairwise-equality word, one row per cycle.
module vector5_pair_decoder
  import vector5_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_bits,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  state_t           state;
  state_t           state_nx;
  logic [W-1:0]     word_q;
  logic [N-1:0]     ref_q;
  logic [2:0]       row_q;
  logic             err_q;
  logic [N-1:0]     bits_q;
  logic             out_err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N-1:0]     row_bits;
  logic             row_mis;
  logic             accept;
  logic             last_row;
  logic             word_err;

  always_comb begin
    case (row_q)
      3'd0:    row_bits = word_q[pair_idx(0, 0) -: N];
      3'd1:    row_bits = word_q[pair_idx(1, 0) -: N];
      3'd2:    row_bits = word_q[pair_idx(2, 0) -: N];
      3'd3:    row_bits = word_q[pair_idx(3, 0) -: N];
      3'd4:    row_bits = word_q[pair_idx(4, 0) -: N];
      default: row_bits = '0;
    endcase
  end

  vector5_row_check u_row_check (
    .row      (row_bits),
    .ref_vec  (ref_q),
    .row_idx  (row_q),
    .mismatch (row_mis)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    last_row  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (row_q == 3'd4) begin
          last_row = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign word_err = err_q | row_mis;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q    <= '0;
      ref_q     <= '0;
      row_q     <= '0;
      err_q     <= 1'b0;
      bits_q    <= '0;
      out_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        word_q <= in_word;
        // Row 0 fixes the reference; a well-formed word always yields ref[a] = 0.
        ref_q  <= ~in_word[pair_idx(0, 0) -: N];
        row_q  <= '0;
        err_q  <= 1'b0;
      end
      if (state == CHECK) begin
        row_q <= last_row ? 3'd0 : row_q + 3'd1;
        err_q <= word_err;
      end
      if (last_row) begin
        bits_q    <= ref_q;
        out_err_q <= word_err;
        if (word_err && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_bits  = bits_q;
  assign out_err   = out_err_q;
  assign err_count = cnt_q;

endmodule

// File: doc/vector5_pair_decoder.md
Name: vector5_pair_decoder

Overview:
- Inverse of the 5-input pairwise-equality encoder, which produces a 25-bit word with bit (24 − 5r − c) = 1 iff x_r == x_c, for inputs x0..x4 = a..e.
- Accepts one 25-bit encoded word over a valid/ready handshake and checks it row by row, one row per cycle.
- Recovers the 5-bit source. The source is only recoverable up to global inversion, so the output is normalized to a = 0.
- Flags any word that no 5-bit input could produce. Sits on the consumer side of the encoder's output, for self-check and loopback.

Parameters:
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  encoded word valid.
- in_ready  output  1  decoder can accept a word.
- in_word  input  25  encoded pairwise-equality word.
- out_valid  output  1  decode result valid.
- out_ready  input  1  consumer accepts the result.
- out_bits  output  5  recovered {a,b,c,d,e}; a is always 0.
- out_err  output  1  word inconsistent with any 5-bit input.
- err_count  output  CNT_W  saturating count of words completed with out_err = 1.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_bits = 0, out_err = 0, err_count = 0, row index = 0, captured word = 0.
- Bit mapping: E(r,c) = in_word[24 − 5r − c], with r, c in 0..4 and index 0 = a.

FSM states: IDLE, CHECK, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture the word, clear the sticky error, set row = 0, go to CHECK.
  - Reference vector is taken from row 0: ref_c = ~E(0,c). This forces ref_0 = 0 when the word is well formed.
- CHECK:
  - in_ready = 0.
  - Each cycle processes row r: for every c, expected = ~(ref_r ^ ref_c); any E(r,c) != expected sets the sticky error.
  - Row 0 check includes E(0,0) = 1. If E(0,0) = 0, ref_0 = 1 and the error is set.
  - After r = 4, go to DONE: out_bits = ref vector, out_err = sticky error; if the error is set, increment err_count, saturating at all-ones.
- DONE:
  - out_valid = 1; out_bits and out_err are held stable while out_ready = 0.
  - On out_ready: out_valid falls next cycle, go to IDLE.
  - No bypass: a new word is not accepted in the same cycle as output acceptance.

Latency:
- Word accepted at edge T; rows checked on edges T+1..T+5; out_valid first high in the cycle after edge T+5.
- Back-to-back throughput: one word per 7 cycles.

Boundaries and special cases:
- in_word may change freely after acceptance; only the captured copy is used.
- in_valid is ignored outside IDLE.
- Reset in any state (including mid-CHECK, or DONE with out_ready = 0) returns all state to the reset values next edge and discards the word; err_count also clears.
- All five outputs of an erroneous word are still reported; out_bits is the row-0 reference.

Decomposition:
- Shared package vector5_pkg:
  - N = 5, W = 25.
  - Enum state_t {IDLE, CHECK, DONE}.
  - Function pair_idx(r,c) = 24 − 5r − c, also used by the encoder testbench model.
- One natural sub-module: vector5_row_check, purely combinational. Inputs: 5-bit row, 5-bit reference, row index. Output: mismatch.
- FSM, capture register and counter live in the top.

Test Plan:
- Valid word: a..e = 1,0,1,1,0 encodes to in_word = 0x164DAC9 → after 6 cycles out_valid = 1, out_bits = 5'b01001, out_err = 0, err_count = 0.
- All-equal input: in_word = 0x1FFFFFF → out_bits = 5'b00000, out_err = 0.
- Single-bit corruption: 0x164DAC8 (E(4,4) cleared) → out_err = 1, err_count = 1. All-zero word 0x0000000 → out_err = 1, err_count = 2.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → out_valid, out_bits and out_err stay constant; in_ready = 0; a new in_valid pulse is ignored.
- Reset mid-CHECK: assert reset on the 3rd CHECK cycle → next cycle state is IDLE, in_ready = 1, out_valid = 0, err_count = 0; the following word 0x1FFFFFF decodes normally.
- Saturation: with CNT_W = 2, send 5 erroneous words → err_count reads 1, 2, 3, 3, 3.
